// File: rtl/apu_pulse_regs.sv
// APU pulse register writer: decodes CPU writes to $4000-$4007/$4015 and
// drives both pulse channels with control fields and one-shot load strobes.
// Ports: clk, rst_l (async, active-low), cpu_clk_en, reg_we/reg_re,
//   reg_addr[4:0], reg_wdata[7:0], len_nz1/2 -> rd_data/rd_valid and
//   per channel pN_duty, pN_length_halt, pN_const_vol, pN_vol,
//   pN_sweep_sigs, pN_timer_period, pN_length_load_data,
//   pN_env_load, pN_sweep_load, pN_length_load, pN_disable_l.
// Option: define APU_PULSE_READBACK_EN to build the $4015 status read.

package apu_pulse_pkg;
  typedef struct packed {
    logic       enable;
    logic [2:0] period;
    logic       negate;
    logic [2:0] shift_count;
  } sweep_t;
endpackage

module apu_pulse_regs
  import apu_pulse_pkg::*;
(
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cpu_clk_en,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [4:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        len_nz1,
  input  logic        len_nz2,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [1:0]  p1_duty,
  output logic        p1_length_halt,
  output logic        p1_const_vol,
  output logic [3:0]  p1_vol,
  output sweep_t      p1_sweep_sigs,
  output logic [10:0] p1_timer_period,
  output logic [4:0]  p1_length_load_data,
  output logic        p1_env_load,
  output logic        p1_sweep_load,
  output logic        p1_length_load,
  output logic        p1_disable_l,
  output logic [1:0]  p2_duty,
  output logic        p2_length_halt,
  output logic        p2_const_vol,
  output logic [3:0]  p2_vol,
  output sweep_t      p2_sweep_sigs,
  output logic [10:0] p2_timer_period,
  output logic [4:0]  p2_length_load_data,
  output logic        p2_env_load,
  output logic        p2_sweep_load,
  output logic        p2_length_load,
  output logic        p2_disable_l
);

  logic              w_wr;
  logic              w_st_wr;
  logic [1:0][3:0]   w_sel;

  logic [1:0][1:0]   r_duty;
  logic [1:0]        r_halt;
  logic [1:0]        r_cvol;
  logic [1:0][3:0]   r_vol;
  sweep_t [1:0]      r_sweep;
  logic [1:0][10:0]  r_timer;
  logic [1:0][4:0]   r_lld;
  logic [1:0]        r_env_ld;
  logic [1:0]        r_sw_ld;
  logic [1:0]        r_len_ld;
  logic [1:0]        r_en;

  assign w_wr    = cpu_clk_en & reg_we;
  assign w_st_wr = w_wr & (reg_addr == 5'h15);

  always_comb begin
    w_sel = '0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) begin
        w_sel[c][k] = w_wr & (reg_addr == 5'(4 * c + k));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_duty   <= '0;
      r_halt   <= '0;
      r_cvol   <= '0;
      r_vol    <= '0;
      r_sweep  <= '0;
      r_timer  <= '0;
      r_lld    <= '0;
      r_env_ld <= '0;
      r_sw_ld  <= '0;
      r_len_ld <= '0;
      r_en     <= '0;
    end else begin
      if (w_st_wr) begin
        r_en <= reg_wdata[1:0];
      end
      for (int c = 0; c < 2; c++) begin
        if (w_sel[c][0]) begin
          r_duty[c] <= reg_wdata[7:6];
          r_halt[c] <= reg_wdata[5];
          r_cvol[c] <= reg_wdata[4];
          r_vol[c]  <= reg_wdata[3:0];
        end
        if (w_sel[c][1]) begin
          r_sweep[c] <= sweep_t'(reg_wdata);
        end
        if (w_sel[c][2]) begin
          r_timer[c][7:0] <= reg_wdata;
        end
        if (w_sel[c][3]) begin
          r_timer[c][10:8] <= reg_wdata[2:0];
          r_lld[c]         <= reg_wdata[7:3];
        end
        // A qualified cycle retires the pending flag unless a new
        // write to the same register re-arms it in that cycle.
        if (cpu_clk_en) begin
          r_sw_ld[c]  <= w_sel[c][1];
          r_env_ld[c] <= w_sel[c][3];
          r_len_ld[c] <= w_sel[c][3] & r_en[c];
        end
      end
    end
  end

`ifdef APU_PULSE_READBACK_EN
  logic       w_rd;
  logic [7:0] r_rd_data;
  logic       r_rd_valid;

  assign w_rd = cpu_clk_en & reg_re & (reg_addr == 5'h15);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= {6'b0, len_nz2, len_nz1};
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`else
  logic w_unused_rd;

  assign w_unused_rd = ^{reg_re, len_nz1, len_nz2};
  assign rd_data     = 8'h00;
  assign rd_valid    = 1'b0;
`endif

  assign p1_duty             = r_duty[0];
  assign p1_length_halt      = r_halt[0];
  assign p1_const_vol        = r_cvol[0];
  assign p1_vol              = r_vol[0];
  assign p1_sweep_sigs       = r_sweep[0];
  assign p1_timer_period     = r_timer[0];
  assign p1_length_load_data = r_lld[0];
  assign p1_env_load         = r_env_ld[0];
  assign p1_sweep_load       = r_sw_ld[0];
  assign p1_length_load      = r_len_ld[0];
  assign p1_disable_l        = r_en[0];

  assign p2_duty             = r_duty[1];
  assign p2_length_halt      = r_halt[1];
  assign p2_const_vol        = r_cvol[1];
  assign p2_vol              = r_vol[1];
  assign p2_sweep_sigs       = r_sweep[1];
  assign p2_timer_period     = r_timer[1];
  assign p2_length_load_data = r_lld[1];
  assign p2_env_load         = r_env_ld[1];
  assign p2_sweep_load       = r_sw_ld[1];
  assign p2_length_load      = r_len_ld[1];
  assign p2_disable_l        = r_en[1];

endmodule

// File: tb/tb_apu_pulse_regs.sv
// Scoreboard bench for apu_pulse_regs: expected field values and strobe
// events are queued by the stimulus and checked by a negedge monitor.
module tb_apu_pulse_regs;
  import apu_pulse_pkg::*;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        cpu_clk_en = 1'b0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic [7:0]  reg_wdata = '0;
  logic        len_nz1 = 1'b0;
  logic        len_nz2 = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [1:0]  p1_duty, p2_duty;
  logic        p1_length_halt, p2_length_halt;
  logic        p1_const_vol, p2_const_vol;
  logic [3:0]  p1_vol, p2_vol;
  sweep_t      p1_sweep_sigs, p2_sweep_sigs;
  logic [10:0] p1_timer_period, p2_timer_period;
  logic [4:0]  p1_length_load_data, p2_length_load_data;
  logic        p1_env_load, p2_env_load;
  logic        p1_sweep_load, p2_sweep_load;
  logic        p1_length_load, p2_length_load;
  logic        p1_disable_l, p2_disable_l;

  apu_pulse_regs dut (
    .clk(clk), .rst_l(rst_l), .cpu_clk_en(cpu_clk_en),
    .reg_we(reg_we), .reg_re(reg_re),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .len_nz1(len_nz1), .len_nz2(len_nz2),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .p1_duty(p1_duty), .p1_length_halt(p1_length_halt),
    .p1_const_vol(p1_const_vol), .p1_vol(p1_vol),
    .p1_sweep_sigs(p1_sweep_sigs),
    .p1_timer_period(p1_timer_period),
    .p1_length_load_data(p1_length_load_data),
    .p1_env_load(p1_env_load), .p1_sweep_load(p1_sweep_load),
    .p1_length_load(p1_length_load),
    .p1_disable_l(p1_disable_l),
    .p2_duty(p2_duty), .p2_length_halt(p2_length_halt),
    .p2_const_vol(p2_const_vol), .p2_vol(p2_vol),
    .p2_sweep_sigs(p2_sweep_sigs),
    .p2_timer_period(p2_timer_period),
    .p2_length_load_data(p2_length_load_data),
    .p2_env_load(p2_env_load), .p2_sweep_load(p2_sweep_load),
    .p2_length_load(p2_length_load),
    .p2_disable_l(p2_disable_l)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tgt;
    int          sel;
    logic [15:0] exp;
  } fchk_t;

  typedef struct {
    logic [6:0] strb;
    logic [7:0] rdat;
  } ev_t;

  // strobe vector bit order
  localparam logic [6:0] E1 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b0100000;
  localparam logic [6:0] L1 = 7'b0010000;
  localparam logic [6:0] E2 = 7'b0001000;
  localparam logic [6:0] S2 = 7'b0000100;
  localparam logic [6:0] L2 = 7'b0000010;
  localparam logic [6:0] RV = 7'b0000001;

  fchk_t fq[$];
  ev_t   eq[$];
  int    checks = 0;
  int    failures = 0;
  bit    div4 = 1'b0;

  function automatic logic [15:0] get(int sel);
    case (sel)
      0:  return 16'(p1_duty);
      1:  return 16'(p1_length_halt);
      2:  return 16'(p1_const_vol);
      3:  return 16'(p1_vol);
      4:  return 16'(p1_sweep_sigs);
      5:  return 16'(p1_timer_period);
      6:  return 16'(p1_length_load_data);
      7:  return 16'(p1_disable_l);
      8:  return 16'(p2_duty);
      9:  return 16'(p2_length_halt);
      10: return 16'(p2_const_vol);
      11: return 16'(p2_vol);
      12: return 16'(p2_sweep_sigs);
      13: return 16'(p2_timer_period);
      14: return 16'(p2_length_load_data);
      15: return 16'(p2_disable_l);
      16: return 16'(rd_data);
      17: return 16'(rd_valid);
      default: return 16'hDEAD;
    endcase
  endfunction

  string nm[18] = '{"p1_duty", "p1_halt", "p1_cvol", "p1_vol",
    "p1_sweep", "p1_timer", "p1_lld", "p1_dis_l",
    "p2_duty", "p2_halt", "p2_cvol", "p2_vol",
    "p2_sweep", "p2_timer", "p2_lld", "p2_dis_l",
    "rd_data", "rd_valid"};

  // monitor
  always @(negedge clk) begin
    logic [6:0]  obs;
    logic [15:0] got;
    fchk_t       f;
    ev_t         e;
    obs = {p1_env_load, p1_sweep_load, p1_length_load,
           p2_env_load, p2_sweep_load, p2_length_load,
           rd_valid};
    while (fq.size() > 0 && fq[0].tgt <= cyc) begin
      f = fq.pop_front();
      got = get(f.sel);
      checks++;
      if (got !== f.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h exp=%h",
                 nm[f.sel], cyc, got, f.exp);
      end
    end
    if (obs != 7'b0) begin
      checks++;
      if (eq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d got=%b exp=none",
                 cyc, obs);
      end else begin
        e = eq.pop_front();
        if (obs !== e.strb ||
            (e.strb[0] && rd_data !== e.rdat)) begin
          failures++;
          $display("FAIL strobe cyc=%0d got=%b/%h exp=%b/%h",
                   cyc, obs, rd_data, e.strb, e.rdat);
        end
      end
    end
  end

  task automatic expf(int sel, logic [15:0] v);
    fq.push_back('{tgt: cyc + 1, sel: sel, exp: v});
  endtask

  task automatic expe(logic [6:0] s, logic [7:0] r, int n);
    for (int i = 0; i < n; i++) eq.push_back('{strb: s, rdat: r});
  endtask

  task automatic drive(bit we, bit re, logic [4:0] a, logic [7:0] d);
    cpu_clk_en = div4 ? (cyc % 4 == 0) : 1'b1;
    reg_we = we;
    reg_re = re;
    reg_addr = a;
    reg_wdata = d;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(0, 0, 5'h00, 8'h00);
    end
  endtask

  // Issues the access on the next enabled cycle.
  task automatic acc(bit we, bit re, logic [4:0] a, logic [7:0] d);
    @(negedge clk);
    for (int i = 0; i < 4 && div4 && (cyc % 4 != 0); i++) begin
      drive(0, 0, 5'h00, 8'h00);
      @(negedge clk);
    end
    drive(we, re, a, d);
  endtask

  initial begin
    idle(3);
    for (int s = 0; s < 18; s++) expf(s, 16'h0);
    idle(1);
    rst_l = 1'b1;
    idle(2);

    // $00 <- BF
    acc(1, 0, 5'h00, 8'hBF);
    expf(0, 16'h2); expf(1, 16'h1);
    expf(2, 16'h1); expf(3, 16'hF);
    idle(2);

    // enable p1 then load timer/length
    acc(1, 0, 5'h15, 8'h01);
    acc(1, 0, 5'h02, 8'hFD);
    acc(1, 0, 5'h03, 8'hF9);
    expf(5, 16'h1FD); expf(6, 16'h1F); expf(7, 16'h1);
    expe(E1 | L1, 8'h00, 1);
    idle(3);

    // disabled p2: env only
    acc(1, 0, 5'h15, 8'h00);
    acc(1, 0, 5'h07, 8'h08);
    expf(14, 16'h1); expf(15, 16'h0);
    expf(7, 16'h0); expf(13, 16'h000);
    expe(E2, 8'h00, 1);
    idle(3);

    // unmapped offsets ignored
    acc(1, 0, 5'h08, 8'hFF);
    acc(1, 0, 5'h16, 8'hFF);
    expf(0, 16'h2); expf(3, 16'hF);
    expf(7, 16'h0); expf(15, 16'h0);
    idle(2);

    // sparse enable: strobe spans to next enabled cycle
    div4 = 1'b1;
    acc(1, 0, 5'h05, 8'h8A);
    expf(12, 16'h8A);
    expe(S2, 8'h00, 4);
    idle(10);
    div4 = 1'b0;
    idle(2);

    // back-to-back sweep writes: no gap
    acc(1, 0, 5'h01, 8'h11);
    expe(S1, 8'h00, 1);
    acc(1, 0, 5'h01, 8'h22);
    expe(S1, 8'h00, 1);
    expf(4, 16'h22);
    idle(3);

    // status read
    len_nz1 = 1'b1;
    len_nz2 = 1'b0;
    acc(0, 1, 5'h15, 8'h00);
`ifdef APU_PULSE_READBACK_EN
    expe(RV, 8'h01, 1);
`else
    expf(17, 16'h0); expf(16, 16'h00);
`endif
    idle(2);
    acc(0, 1, 5'h14, 8'h00);
    expf(17, 16'h0);
    idle(2);

    // write + read together, then both length loads
    len_nz1 = 1'b0;
    len_nz2 = 1'b1;
    acc(1, 1, 5'h15, 8'h03);
`ifdef APU_PULSE_READBACK_EN
    expe(RV, 8'h02, 1);
`endif
    expf(7, 16'h1); expf(15, 16'h1);
    acc(1, 0, 5'h03, 8'hA8);
    expf(5, 16'h0FD); expf(6, 16'h15);
    expe(E1 | L1, 8'h00, 1);
    idle(2);
    acc(1, 0, 5'h07, 8'h13);
    expf(13, 16'h300); expf(14, 16'h02);
    expe(E2 | L2, 8'h00, 1);
    idle(3);

    // reset with strobes pending
    div4 = 1'b1;
    acc(1, 0, 5'h03, 8'h08);
    @(posedge clk);
    #1 rst_l = 1'b0;
    idle(2);
    expf(6, 16'h0); expf(7, 16'h0);
    expf(5, 16'h0); expf(0, 16'h0);
    idle(1);
    rst_l = 1'b1;
    idle(10);
    div4 = 1'b0;
    idle(3);

    checks++;
    if (fq.size() != 0 || eq.size() != 0) begin
      failures++;
      $display("FAIL leftover got=%0d/%0d exp=0/0",
               fq.size(), eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apu_pulse_regs.md
# apu_pulse_regs

CPU-facing register writer for both APU pulse channels. Decodes CPU writes to $4000–$4007 and $4015. Holds the channel control fields and issues one-shot load strobes for the envelope, sweep and length units, presented to each `pulse_channel` instance. Optionally returns the $4015 length-status readback. It sits between the CPU bus decode and the two `pulse_channel` instances inside the APU top.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock; the single clock domain.
- `rst_l` in 1: asynchronous, active-low reset.
- `cpu_clk_en` in 1: CPU-cycle enable; qualifies writes, reads and strobe retirement.
- `reg_we` in 1: write request, sampled when `cpu_clk_en`=1.
- `reg_re` in 1: read request, sampled when `cpu_clk_en`=1.
- `reg_addr` in 5: register offset from $4000 ($00–$17).
- `reg_wdata` in 8: write data.
- `len_nz1`, `len_nz2` in 1 each: `length_non_zero` from pulse 1 and pulse 2.
- `rd_data` out 8: $4015 status byte.
- `rd_valid` out 1: `rd_data` valid.
- `pN_duty` out 2: duty select; N = 1, 2.
- `pN_length_halt` out 1: length halt / envelope loop.
- `pN_const_vol` out 1: constant-volume flag.
- `pN_vol` out 4: volume / envelope period.
- `pN_sweep_sigs` out `sweep_t`: fields enable, period, negate, shift_count.
- `pN_timer_period` out 11: timer period.
- `pN_length_load_data` out 5: length table index.
- `pN_env_load`, `pN_sweep_load`, `pN_length_load` out 1 each: one-shot load strobes.
- `pN_disable_l` out 1: 0 = channel disabled.

## Operation
- A write is accepted on a `clk` edge with `cpu_clk_en` & `reg_we`. Offsets outside {$00–$07, $15} are ignored. Base offsets are $00 for p1 and $04 for p2.
- Base+0 (data D): duty = D[7:6], length_halt = D[5], const_vol = D[4], vol = D[3:0].
- Base+1: sweep enable = D[7], period = D[6:4], negate = D[3], shift_count = D[2:0]. Sets the sweep_load pending flag.
- Base+2: timer_period[7:0] = D.
- Base+3: timer_period[10:8] = D[2:0]; length_load_data = D[7:3]. Sets env_load pending. Sets length_load pending only if that channel's enable bit = 1.
- $15: enable1 = D[0], enable2 = D[1]; pN_disable_l = enableN. Other bits are ignored.
- Strobe rule, applied per pending flag: the flag is set at the accepting edge and drives its strobe output directly. It clears at the first subsequent edge where `cpu_clk_en`=1. The channel therefore sees exactly one `cpu_clk_en`-qualified cycle of the strobe.
- Simultaneous clear and new write to the same flag: the set wins, and the flag stays 1 for one more qualified cycle.
- `reg_we` and `reg_re` both high: the write is performed and the read is also served. The read returns the status sampled before the write.

## Timing
- All field outputs are registered. They change at the accepting edge and are visible the cycle after.
- Strobe latency: asserted the cycle after the accepting edge.
  - With `cpu_clk_en` continuously high, the strobe is exactly 1 cycle wide.
  - Otherwise the strobe stays high through the next `cpu_clk_en` cycle.
- Read: `rd_data` and `rd_valid` are registered, with 1-cycle latency after the qualified `reg_re` at $15. `rd_data` = {6'b0, len_nz2, len_nz1}. `rd_valid` is a 1-cycle pulse.
- A read at any other offset gives no `rd_valid`.
- Reset values (asynchronous): every field 0, every strobe 0, enables 0 (`pN_disable_l`=0), `rd_data`=0, `rd_valid`=0.
- Reset asserted with strobes pending drops them immediately; no strobe is emitted after release.

## Configuration
- `APU_PULSE_READBACK_EN` defined: the $4015 read path described above is built.
- Not defined: `rd_data` is tied to 8'h00, `rd_valid` is tied to 0, `reg_re` is ignored, and no read registers are inferred.

## Test plan
- Reset, then write $00 ← 8'hBF with `cpu_clk_en` always 1 → p1_duty=2, length_halt=1, const_vol=1, vol=4'hF next cycle; no strobes.
- Write $15 ← 8'h01, $02 ← 8'hFD, $03 ← 8'hF9 → p1_timer_period=11'h1FD, length_load_data=5'h1F, and env_load and length_load each high for exactly 1 cycle.
- With $15=8'h00, write $07 ← 8'h08 → p2_env_load pulses, p2_length_load stays 0, p2_disable_l=0.
- With `cpu_clk_en` every 4th cycle, write $05 ← 8'h8A → p2_sweep_load is high from the edge after acceptance through the next enabled cycle. Sweep fields read enable=1, period=0, negate=1, shift_count=2.
- Two back-to-back $01 writes on consecutive enabled cycles → p1_sweep_load stays high continuously for 2 qualified cycles, with no gap.
- With the macro on, len_nz1=1 and len_nz2=0, read $15 → rd_valid pulse with rd_data=8'h01. With the macro off → rd_valid never asserts.
